// File: rtl/pool_stream.sv
// pool_stream: multi-channel max/average pooling stage that gathers OUT_LEN
// pooled pixels per channel into one frame and hands it out over valid/ready.
`default_nettype none

module pool_stream #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 8,
  parameter int WIN     = 4,
  parameter int OUT_LEN = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CH*DATA_W-1:0]          in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*OUT_LEN*DATA_W-1:0]  out_data,
  output logic                              busy
);

  localparam int LOGW    = $clog2(WIN);
  localparam int ACC_W   = DATA_W + LOGW;
  localparam int SW      = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int PW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int FRAME_W = NUM_CH * OUT_LEN * DATA_W;
  localparam logic [SW-1:0] S_LAST = SW'(WIN - 1);
  localparam logic [PW-1:0] P_LAST = PW'(OUT_LEN - 1);

  logic [SW-1:0]              s_cnt_q, s_cnt_d;
  logic [PW-1:0]              p_cnt_q, p_cnt_d;
  logic                       mode_q, mode_d;
  logic [FRAME_W-1:0]         collect_q, collect_d;
  logic [FRAME_W-1:0]         out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_W-1:0]   w_pooled;

  logic w_accept, w_s_first, w_s_last, w_p_last, w_win_close, w_frame_close;

  assign w_s_first     = (s_cnt_q == '0);
  assign w_s_last      = (s_cnt_q == S_LAST);
  assign w_p_last      = (p_cnt_q == P_LAST);
  // Only the frame-closing beat needs the output slot, so only it is stalled.
  assign in_ready      = !(out_valid_q && !out_ready && w_s_last && w_p_last);
  assign w_accept      = in_valid && in_ready;
  assign w_win_close   = w_accept && w_s_last;
  assign w_frame_close = w_win_close && w_p_last;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (s_cnt_q != '0) || (p_cnt_q != '0);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_W-1:0] w_sample;
      logic [ACC_W-1:0]  w_ext;
      logic [ACC_W-1:0]  w_acc_next;
      logic [ACC_W-1:0]  w_shift;
      logic [ACC_W-1:0]  acc_q;

      assign w_sample = in_data[c*DATA_W +: DATA_W];
      assign w_ext    = ACC_W'(w_sample);

      // The first sample of a window loads the accumulator in either mode.
      always_comb begin
        w_acc_next = w_ext;
        if (!w_s_first) begin
          if (mode_q) w_acc_next = acc_q + w_ext;
          else        w_acc_next = (w_ext > acc_q) ? w_ext : acc_q;
        end
      end

      assign w_shift = w_acc_next >> LOGW;
      assign w_pooled[c*DATA_W +: DATA_W] = mode_q ? w_shift[DATA_W-1:0]
                                                   : w_acc_next[DATA_W-1:0];

      always_ff @(posedge clk) begin
        if (rst)           acc_q <= '0;
        else if (w_accept) acc_q <= w_acc_next;
      end
    end
  endgenerate

  always_comb begin
    s_cnt_d     = s_cnt_q;
    p_cnt_d     = p_cnt_q;
    mode_d      = mode_q;
    collect_d   = collect_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;

    if (w_accept) begin
      s_cnt_d = w_s_last ? '0 : s_cnt_q + 1'b1;
      if (w_s_last) p_cnt_d = w_p_last ? '0 : p_cnt_q + 1'b1;
      if (w_s_first && (p_cnt_q == '0)) mode_d = mode;
    end

    if (w_win_close) begin
      for (int c = 0; c < NUM_CH; c++) begin
        collect_d[(c*OUT_LEN + int'(p_cnt_q))*DATA_W +: DATA_W] =
          w_pooled[c*DATA_W +: DATA_W];
      end
    end

    // Loading from collect_d picks up the pixel produced on this very beat.
    if (w_frame_close) begin
      out_data_d  = collect_d;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_cnt_q     <= '0;
      p_cnt_q     <= '0;
      mode_q      <= 1'b0;
      collect_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s_cnt_q     <= s_cnt_d;
      p_cnt_q     <= p_cnt_d;
      mode_q      <= mode_d;
      collect_q   <= collect_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pool_stream.sv
// tb_pool_stream: directed stimulus with a frame scoreboard drained by an
// independent output monitor.
`default_nettype none

module tb_pool_stream;

  logic        clk = 1'b0;
  logic        rst, mode, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [63:0] out_data;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  logic [7:0] pat_a [16] = '{3,9,1,7, 0,0,0,0, 255,1,2,3, 5,5,6,5};
  logic [7:0] pat_b [16] = '{255,255,255,254, 1,2,2,2, 4,4,4,4, 0,0,0,3};

  // Frames packed as {ch1 p3..p0, ch0 p3..p0}.
  localparam logic [63:0] A_MAX = {8'd7, 8'd255, 8'd1, 8'd10, 8'd6, 8'd255, 8'd0, 8'd9};
  localparam logic [63:0] A_AVG = {8'd6, 8'd66,  8'd1, 8'd6,  8'd5, 8'd65,  8'd0, 8'd5};
  localparam logic [63:0] B_MAX = {8'd4, 8'd5,   8'd3, 8'd255, 8'd3, 8'd4,  8'd2, 8'd255};
  localparam logic [63:0] B_AVG = {8'd1, 8'd5,   8'd2, 8'd255, 8'd0, 8'd4,  8'd1, 8'd254};

  always #5 clk = ~clk;

  pool_stream #(.NUM_CH(2), .DATA_W(8), .WIN(4), .OUT_LEN(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check64("frame", out_data, mon_exp);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [7:0] v, input logic m);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_data  = {((v == 8'd255) ? 8'd255 : v + 8'd1), v};
    mode     = m;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (n > 1) stalls++;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input logic m0, input logic m1,
                            input int sw, input bit lat);
    for (int i = 0; i < 16; i++) begin
      if (lat && i == 15) check64("lat_before", 64'(out_valid), 64'd0);
      send_beat(sel ? pat_b[i] : pat_a[i], (i < sw) ? m0 : m1);
    end
    if (lat) check64("lat_after", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check64("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check64("rst_in_ready", 64'(in_ready), 64'd1);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_out_valid", 64'(out_valid), 64'd0);
    check64("rst_out_data", out_data, 64'd0);

    // Max mode, then average mode with truncation and full-scale sums.
    exp_q.push_back(A_MAX);
    send_frame(1'b0, 1'b0, 1'b0, 16, 1'b1);
    exp_q.push_back(B_AVG);
    send_frame(1'b1, 1'b1, 1'b1, 16, 1'b1);
    drain();

    // Backpressure: frame 1 held while frame 2's closing beat waits.
    out_ready = 1'b0;
    exp_q.push_back(A_MAX);
    send_frame(1'b0, 1'b0, 1'b0, 16, 1'b1);
    exp_q.push_back(B_AVG);
    for (int i = 0; i < 15; i++) send_beat(pat_b[i], 1'b1);
    check64("bp_no_stall_15", 64'(stalls), 64'd0);
    in_valid = 1'b1;
    in_data  = {8'd4, 8'd3};
    repeat (3) begin
      @(negedge clk);
      check64("bp_in_ready", 64'(in_ready), 64'd0);
      check64("bp_out_valid", 64'(out_valid), 64'd1);
      check64("bp_hold_data", out_data, A_MAX);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    #1 check64("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check64("bp_valid_kept", 64'(out_valid), 64'd1);
    check64("bp_new_data", out_data, B_AVG);
    drain();

    // Mode change after beat 5 is ignored until the next frame.
    exp_q.push_back(B_MAX);
    send_frame(1'b1, 1'b0, 1'b1, 5, 1'b1);
    exp_q.push_back(B_AVG);
    send_frame(1'b1, 1'b1, 1'b1, 16, 1'b1);
    drain();

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 6; i++) send_beat(8'd200, 1'b0);
    check64("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check64("mid_rst_busy", 64'(busy), 64'd0);
    check64("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check64("mid_rst_out_data", out_data, 64'd0);
    check64("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(A_MAX);
    send_frame(1'b0, 1'b0, 1'b0, 16, 1'b1);
    drain();

    // Continuous streaming, four back-to-back frames.
    stalls = 0;
    exp_q.push_back(A_MAX);
    exp_q.push_back(B_AVG);
    exp_q.push_back(B_MAX);
    exp_q.push_back(A_AVG);
    send_frame(1'b0, 1'b0, 1'b0, 16, 1'b1);
    send_frame(1'b1, 1'b1, 1'b1, 16, 1'b1);
    send_frame(1'b1, 1'b0, 1'b0, 16, 1'b1);
    send_frame(1'b0, 1'b1, 1'b1, 16, 1'b1);
    check64("stream_no_stall", 64'(stalls), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
